// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory responder for a multicycle core. Holds a 64-bit
//               word RAM, accepts one load/store at a time over valid/ready,
//               merges store lanes and returns sign/zero-extended load data
//               after a fixed number of WAIT cycles.
//               Optional feature macro: MISALIGN_TRAP_EN (trap misaligned
//               accesses instead of aligning them down).
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int c_AW = $clog2(DEPTH_WORDS);
  localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state, w_state_n;
  logic [c_CW-1:0]   r_cnt;
  logic              r_we;
  logic [2:0]        r_func3;
  logic [c_AW+2:0]   r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic              r_err;
  logic [63:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_finish;
  logic [c_AW-1:0]   w_idx;
  logic [2:0]        w_szm1;
  logic              w_misal;
  logic              w_illegal;
  logic              w_err;
  logic [2:0]        w_off;
  logic [7:0]        w_bmask;
  logic [63:0]       w_word;
  logic [63:0]       w_wsh;
  logic [63:0]       w_merged;
  logic [63:0]       w_rsh;
  logic [63:0]       w_load;
  logic              w_unused_addr;

  // Upper address bits wrap, so they are intentionally dropped.
  assign w_unused_addr = ^req_addr[63:c_AW+3];

  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept   = req_valid && req_ready;
  // WAIT->RESP edge: commit stores and sample load data here.
  assign w_finish   = (r_state == S_WAIT) && (r_cnt == '0) && !reset;
  assign resp_valid = (r_state == S_RESP) && !reset;
  assign resp_rdata = reset ? 64'd0 : r_rdata;
  assign resp_err   = reset ? 1'b0 : r_err;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT counts down, RESP lasts one cycle.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_n = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_state_n = S_RESP;
      S_RESP:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Request capture and WAIT countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_func3 <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 64'd0;
    end else if (w_accept) begin
      r_cnt   <= c_CW'(LATENCY - 1);
      r_we    <= req_we;
      r_func3 <= req_func3;
      r_addr  <= req_addr[c_AW+2:0];
      r_wdata <= req_wdata;
    end else if (r_state == S_WAIT && r_cnt != '0) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  // Access decode: size mask, legality, effective byte offset and lane masks.
  always_comb begin
    w_idx = r_addr[c_AW+2:3];
    case (r_func3[1:0])
      2'd0:    begin w_szm1 = 3'd0; w_bmask = 8'h01; end
      2'd1:    begin w_szm1 = 3'd1; w_bmask = 8'h03; end
      2'd2:    begin w_szm1 = 3'd3; w_bmask = 8'h0F; end
      default: begin w_szm1 = 3'd7; w_bmask = 8'hFF; end
    endcase
    w_misal   = |(r_addr[2:0] & w_szm1);
    w_illegal = r_we ? r_func3[2] : (r_func3 == 3'b111);
`ifdef MISALIGN_TRAP_EN
    w_err     = w_illegal || w_misal;
`else
    w_err     = w_illegal;
`endif
    w_off     = r_addr[2:0] & ~w_szm1;
    w_bmask   = w_bmask << w_off;
  end

  // Store lane merge and load extraction/extension from the addressed word.
  always_comb begin
    w_word   = r_mem[w_idx];
    w_wsh    = r_wdata << {w_off, 3'b000};
    w_merged = w_word;
    for (int b = 0; b < 8; b++) begin
      if (w_bmask[b]) w_merged[8*b +: 8] = w_wsh[8*b +: 8];
    end
    w_rsh = w_word >> {w_off, 3'b000};
    case (r_func3)
      3'b000:  w_load = {{56{w_rsh[7]}},  w_rsh[7:0]};
      3'b001:  w_load = {{48{w_rsh[15]}}, w_rsh[15:0]};
      3'b010:  w_load = {{32{w_rsh[31]}}, w_rsh[31:0]};
      3'b011:  w_load = w_rsh;
      3'b100:  w_load = {56'd0, w_rsh[7:0]};
      3'b101:  w_load = {48'd0, w_rsh[15:0]};
      3'b110:  w_load = {32'd0, w_rsh[31:0]};
      default: w_load = 64'd0;
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_finish && r_we && !w_err) r_mem[w_idx] <= w_merged;
  end

  // Response registers hold until the next RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else if (w_finish) begin
      r_rdata <= (r_we || w_err) ? 64'd0 : w_load;
      r_err   <= w_err;
    end
  end

endmodule
`default_nettype wire
